// File: rtl/uart_frame_pkg.sv
// Shared constants and types for the framed UART receiver.
package uart_frame_pkg;

  localparam logic [7:0] FRAME_H0 = 8'h55;
  localparam logic [7:0] FRAME_H1 = 8'hAA;

  typedef enum logic [2:0] {
    StIdle,
    StHdr1,
    StLen,
    StData,
    StChk
  } frame_state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage

// File: rtl/uart_frame_rx_if.sv
// Frame delivery bundle: payload, length, good/abort pulses and abort cause.
interface uart_frame_rx_if #(
  parameter int unsigned MAX_LEN = 8
);
  logic [MAX_LEN*8-1:0] frame_data;
  logic [7:0]           frame_len;
  logic                 frame_vld;
  logic                 frame_err;
  logic [1:0]           err_code;

  modport master (
    output frame_data,
    output frame_len,
    output frame_vld,
    output frame_err,
    output err_code
  );

  modport slave (
    input frame_data,
    input frame_len,
    input frame_vld,
    input frame_err,
    input err_code
  );
endinterface

// File: rtl/uart_rx.sv
// Single-byte UART receiver, 8N1, LSB first; pulses uart_rx_done mid stop bit.
module uart_rx #(
  parameter int unsigned BPS     = 9600,
  parameter int unsigned CLK_FRE = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic       uart_rx_done,
  output logic [7:0] uart_rx_data
);
  localparam int unsigned BitClks = CLK_FRE / BPS;
  localparam int unsigned CntW    = $clog2(BitClks);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e       state_q, state_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d, data_q, data_d;
  logic            done_q, done_d;
  logic            rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic            bit_end, bit_mid;

  assign bit_end = (clk_cnt_q == CntW'(BitClks - 1));
  assign bit_mid = (clk_cnt_q == CntW'(BitClks / 2 - 1));

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    unique case (state_q)
      RxIdle: begin
        clk_cnt_d = '0;
        if (rxd_prev_q && !rxd_sync_q) state_d = RxStart;
      end
      RxStart: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_cnt_d = 3'd0;
          state_d   = RxData;
        end
      end
      RxData: begin
        if (bit_mid) shift_d = {rxd_sync_q, shift_q[7:1]};
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RxStop;
        end
      end
      RxStop: begin
        // Return to idle mid stop bit so a back-to-back start edge is not missed.
        if (bit_mid) begin
          done_d  = 1'b1;
          data_d  = shift_q;
          state_d = RxIdle;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= RxIdle;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  assign uart_rx_done = done_q;
  assign uart_rx_data = data_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Framed UART receiver: 55 AA LEN payload CHK, with resync, length, checksum
// and inter-byte timeout checking.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 8,
  parameter int unsigned BPS          = 9600,
  parameter int unsigned CLK_FRE      = 50_000_000,
  parameter int unsigned TIMEOUT_CLKS = 30 * (CLK_FRE / BPS)
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            uart_rxd,
  uart_frame_rx_if.master frame_if
);
  localparam int unsigned CntW = $clog2(TIMEOUT_CLKS);

  logic       rx_done;
  logic [7:0] rx_data;

  uart_rx #(
    .BPS     (BPS),
    .CLK_FRE (CLK_FRE)
  ) u_uart_rx (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .uart_rxd     (uart_rxd),
    .uart_rx_done (rx_done),
    .uart_rx_data (rx_data)
  );

  frame_state_e          state_q, state_d;
  logic [7:0]            len_q, len_d, sum_q, sum_d, idx_q, idx_d, flen_q, flen_d;
  logic [MAX_LEN-1:0][7:0] shadow_q, shadow_d, data_q, data_d;
  logic                  vld_q, vld_d, err_q, err_d;
  logic [1:0]            code_q, code_d;
  logic [CntW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                  tmo;

  always_comb begin
    // Fire one clock early so the abort pulse lands as the counter hits its limit.
    tmo       = (state_q != StIdle) && !rx_done &&
                (tmo_cnt_q == CntW'(TIMEOUT_CLKS - 2));
    tmo_cnt_d = (state_q == StIdle || rx_done) ? '0 : tmo_cnt_q + 1'b1;
    state_d   = state_q;
    len_d     = len_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    data_d    = data_q;
    flen_d    = flen_q;
    code_d    = code_q;
    vld_d     = 1'b0;
    err_d     = 1'b0;
    if (tmo) begin
      state_d = StIdle;
      err_d   = 1'b1;
      code_d  = ERR_TMO;
    end else if (rx_done) begin
      unique case (state_q)
        StIdle: if (rx_data == FRAME_H0) state_d = StHdr1;
        StHdr1: begin
          if (rx_data == FRAME_H1)      state_d = StLen;
          else if (rx_data != FRAME_H0) state_d = StIdle;
        end
        StLen: begin
          if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
            state_d = StIdle;
            err_d   = 1'b1;
            code_d  = ERR_LEN;
          end else begin
            len_d    = rx_data;
            sum_d    = rx_data;
            shadow_d = '0;
            idx_d    = 8'd0;
            state_d  = StData;
          end
        end
        StData: begin
          for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (idx_q == 8'(i)) shadow_d[i] = rx_data;
          end
          sum_d = sum_q + rx_data;
          idx_d = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) state_d = StChk;
        end
        StChk: begin
          if (rx_data == sum_q) begin
            data_d = shadow_q;
            flen_d = len_q;
            vld_d  = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CHK;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= StIdle;
      len_q     <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      data_q    <= '0;
      flen_q    <= '0;
      code_q    <= ERR_NONE;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      data_q    <= data_d;
      flen_q    <= flen_d;
      code_q    <= code_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign frame_if.frame_data = data_q;
  assign frame_if.frame_len  = flen_q;
  assign frame_if.frame_vld  = vld_q;
  assign frame_if.frame_err  = err_q;
  assign frame_if.err_code   = code_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: serial byte stimulus, pulse monitor, inline checks.
module tb_uart_frame_rx;
  localparam int unsigned BitClks     = 16;
  localparam int unsigned TimeoutClks = 30 * BitClks;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic uart_rxd = 1'b1;

  uart_frame_rx_if #(.MAX_LEN(8)) frame_if ();

  uart_frame_rx #(
    .MAX_LEN (8),
    .BPS     (10),
    .CLK_FRE (160)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_rxd  (uart_rxd),
    .frame_if  (frame_if)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int vld_cnt = 0, err_cnt = 0, both_cnt = 0, long_cnt = 0;
  int last_done_cyc = 0, last_vld_cyc = 0, last_err_cyc = 0;
  logic vld_prev = 1'b0, err_prev = 1'b0;
  logic [7:0] seq [$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (dut.rx_done) last_done_cyc = cyc;
    if (frame_if.frame_vld) begin
      vld_cnt++;
      last_vld_cyc = cyc;
      if (vld_prev) long_cnt++;
    end
    if (frame_if.frame_err) begin
      err_cnt++;
      last_err_cyc = cyc;
      if (err_prev) long_cnt++;
    end
    if (frame_if.frame_vld && frame_if.frame_err) both_cnt++;
    vld_prev = frame_if.frame_vld;
    err_prev = frame_if.frame_err;
  end

  task automatic send_byte(input logic [7:0] b);
    uart_rxd = 1'b0;
    repeat (BitClks) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BitClks) @(negedge sys_clk);
    end
    uart_rxd = 1'b1;
    repeat (BitClks) @(negedge sys_clk);
  endtask

  task automatic send_seq();
    for (int i = 0; i < seq.size(); i++) send_byte(seq[i]);
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    n_cmp++;
    if (frame_if.frame_vld !== 1'b0 || frame_if.frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_pulses: got vld=%b err=%b want 0 0", tag,
               frame_if.frame_vld, frame_if.frame_err);
    end
    n_cmp++;
    if (frame_if.err_code !== 2'd0) begin
      n_bad++;
      $display("FAIL %s_code: got %0d want 0", tag, frame_if.err_code);
    end
    n_cmp++;
    if (frame_if.frame_len !== 8'd0) begin
      n_bad++;
      $display("FAIL %s_len: got %0d want 0", tag, frame_if.frame_len);
    end
    n_cmp++;
    if (frame_if.frame_data !== 64'd0) begin
      n_bad++;
      $display("FAIL %s_data: got %h want 0", tag, frame_if.frame_data);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_zero_outputs("reset");
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_good_frame();
    int v0 = vld_cnt, e0 = err_cnt;
    seq = {8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_seq();
    n_cmp++;
    if (vld_cnt - v0 != 1 || err_cnt - e0 != 0) begin
      n_bad++;
      $display("FAIL good_pulses: got vld=%0d err=%0d want 1 0", vld_cnt - v0, err_cnt - e0);
    end
    n_cmp++;
    if (frame_if.frame_len !== 8'd3) begin
      n_bad++;
      $display("FAIL good_len: got %0d want 3", frame_if.frame_len);
    end
    n_cmp++;
    if (frame_if.frame_data !== 64'h0000_0000_0033_2211) begin
      n_bad++;
      $display("FAIL good_data: got %h want 0000000000332211", frame_if.frame_data);
    end
    n_cmp++;
    if (last_vld_cyc - last_done_cyc != 1) begin
      n_bad++;
      $display("FAIL good_latency: got %0d want 1", last_vld_cyc - last_done_cyc);
    end
  endtask

  task automatic test_bad_checksum();
    int v0 = vld_cnt, e0 = err_cnt;
    seq = {8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68};
    send_seq();
    n_cmp++;
    if (vld_cnt - v0 != 0 || err_cnt - e0 != 1) begin
      n_bad++;
      $display("FAIL chk_pulses: got vld=%0d err=%0d want 0 1", vld_cnt - v0, err_cnt - e0);
    end
    n_cmp++;
    if (frame_if.err_code !== 2'd2) begin
      n_bad++;
      $display("FAIL chk_code: got %0d want 2", frame_if.err_code);
    end
    n_cmp++;
    if (frame_if.frame_len !== 8'd3 || frame_if.frame_data !== 64'h0000_0000_0033_2211) begin
      n_bad++;
      $display("FAIL chk_hold: got len=%0d data=%h want 3 0000000000332211",
               frame_if.frame_len, frame_if.frame_data);
    end
    n_cmp++;
    if (last_err_cyc - last_done_cyc != 1) begin
      n_bad++;
      $display("FAIL chk_latency: got %0d want 1", last_err_cyc - last_done_cyc);
    end
  endtask

  task automatic test_bad_length();
    int e0 = err_cnt;
    seq = {8'h55, 8'hAA, 8'h00};
    send_seq();
    n_cmp++;
    if (err_cnt - e0 != 1 || frame_if.err_code !== 2'd1) begin
      n_bad++;
      $display("FAIL len0: got err=%0d code=%0d want 1 1", err_cnt - e0, frame_if.err_code);
    end
    e0 = err_cnt;
    seq = {8'h55, 8'hAA, 8'h09};
    send_seq();
    n_cmp++;
    if (err_cnt - e0 != 1 || frame_if.err_code !== 2'd1) begin
      n_bad++;
      $display("FAIL len9: got err=%0d code=%0d want 1 1", err_cnt - e0, frame_if.err_code);
    end
  endtask

  task automatic test_max_len();
    int v0 = vld_cnt;
    seq = {8'h55, 8'hAA, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04,
           8'h05, 8'h06, 8'h07, 8'h08, 8'h2C};
    send_seq();
    n_cmp++;
    if (vld_cnt - v0 != 1 || frame_if.frame_len !== 8'd8 ||
        frame_if.frame_data !== 64'h0807_0605_0403_0201) begin
      n_bad++;
      $display("FAIL maxlen: got vld=%0d len=%0d data=%h want 1 8 0807060504030201",
               vld_cnt - v0, frame_if.frame_len, frame_if.frame_data);
    end
    n_cmp++;
    if (frame_if.err_code !== 2'd1) begin
      n_bad++;
      $display("FAIL maxlen_code_hold: got %0d want 1", frame_if.err_code);
    end
  endtask

  task automatic test_resync();
    int v0 = vld_cnt, e0 = err_cnt;
    seq = {8'h12, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h7F, 8'h80};
    send_seq();
    n_cmp++;
    if (vld_cnt - v0 != 1 || err_cnt - e0 != 0) begin
      n_bad++;
      $display("FAIL resync_pulses: got vld=%0d err=%0d want 1 0", vld_cnt - v0, err_cnt - e0);
    end
    n_cmp++;
    if (frame_if.frame_len !== 8'd1 || frame_if.frame_data !== 64'h7F) begin
      n_bad++;
      $display("FAIL resync_frame: got len=%0d data=%h want 1 7f",
               frame_if.frame_len, frame_if.frame_data);
    end
  endtask

  task automatic test_chk_is_header();
    int v0 = vld_cnt, e0 = err_cnt;
    // A 0x55 checksum must not open a frame, so the trailing bytes are ignored.
    seq = {8'h55, 8'hAA, 8'h01, 8'h54, 8'h55, 8'hAA, 8'h01, 8'h07, 8'h08};
    send_seq();
    n_cmp++;
    if (vld_cnt - v0 != 1 || err_cnt - e0 != 0 || frame_if.frame_data !== 64'h54) begin
      n_bad++;
      $display("FAIL chk55: got vld=%0d err=%0d data=%h want 1 0 54",
               vld_cnt - v0, err_cnt - e0, frame_if.frame_data);
    end
  endtask

  task automatic test_back_to_back();
    int v0 = vld_cnt;
    seq = {8'h55, 8'hAA, 8'h01, 8'hA0, 8'hA1, 8'h55, 8'hAA, 8'h02, 8'h01, 8'h02, 8'h05};
    send_seq();
    n_cmp++;
    if (vld_cnt - v0 != 2 || frame_if.frame_len !== 8'd2 || frame_if.frame_data !== 64'h0201) begin
      n_bad++;
      $display("FAIL b2b: got vld=%0d len=%0d data=%h want 2 2 0201",
               vld_cnt - v0, frame_if.frame_len, frame_if.frame_data);
    end
  endtask

  task automatic test_timeout();
    int v0 = vld_cnt, e0 = err_cnt;
    int waited = 0;
    seq = {8'h55, 8'hAA, 8'h04, 8'h01, 8'h02};
    for (int i = 0; i < seq.size(); i++) send_byte(seq[i]);
    while (err_cnt == e0 && waited < int'(TimeoutClks) + 200) begin
      @(negedge sys_clk);
      waited++;
    end
    n_cmp++;
    if (err_cnt - e0 != 1 || vld_cnt - v0 != 0) begin
      n_bad++;
      $display("FAIL tmo_pulses: got err=%0d vld=%0d want 1 0", err_cnt - e0, vld_cnt - v0);
    end
    n_cmp++;
    if (frame_if.err_code !== 2'd3) begin
      n_bad++;
      $display("FAIL tmo_code: got %0d want 3", frame_if.err_code);
    end
    n_cmp++;
    if (last_err_cyc - last_done_cyc != int'(TimeoutClks)) begin
      n_bad++;
      $display("FAIL tmo_delay: got %0d want %0d", last_err_cyc - last_done_cyc, TimeoutClks);
    end
    v0 = vld_cnt;
    seq = {8'h55, 8'hAA, 8'h02, 8'h10, 8'h20, 8'h32};
    send_seq();
    n_cmp++;
    if (vld_cnt - v0 != 1 || frame_if.frame_len !== 8'd2 || frame_if.frame_data !== 64'h2010) begin
      n_bad++;
      $display("FAIL tmo_after: got vld=%0d len=%0d data=%h want 1 2 2010",
               vld_cnt - v0, frame_if.frame_len, frame_if.frame_data);
    end
    n_cmp++;
    if (frame_if.err_code !== 2'd3) begin
      n_bad++;
      $display("FAIL tmo_code_hold: got %0d want 3", frame_if.err_code);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0 = err_cnt;
    seq = {8'h55, 8'hAA, 8'h02, 8'hAB};
    for (int i = 0; i < seq.size(); i++) send_byte(seq[i]);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    check_zero_outputs("midrst");
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    v0 = vld_cnt;
    seq = {8'h55, 8'hAA, 8'h01, 8'h05, 8'h06};
    send_seq();
    n_cmp++;
    if (vld_cnt - v0 != 1 || err_cnt - e0 != 0) begin
      n_bad++;
      $display("FAIL midrst_pulses: got vld=%0d err=%0d want 1 0", vld_cnt - v0, err_cnt - e0);
    end
    n_cmp++;
    if (frame_if.frame_data !== 64'h05 || frame_if.frame_len !== 8'd1) begin
      n_bad++;
      $display("FAIL midrst_frame: got len=%0d data=%h want 1 05",
               frame_if.frame_len, frame_if.frame_data);
    end
  endtask

  task automatic test_pulse_shape();
    n_cmp++;
    if (both_cnt != 0 || long_cnt != 0) begin
      n_bad++;
      $display("FAIL pulse_shape: got overlap=%0d long=%0d want 0 0", both_cnt, long_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_length();
    test_max_len();
    test_resync();
    test_chk_is_header();
    test_back_to_back();
    test_timeout();
    test_reset_mid_frame();
    test_pulse_shape();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Framed UART receive controller: sequences the single-byte `uart_rx` receiver through a header/length/payload/checksum protocol, delivering variable-length frames with validity and error reporting. It replaces the fixed-count byte accumulator in designs where the byte stream must resynchronise after noise, dropped bytes or a half-received frame. It sits between the UART pin and user logic, one instance per RX line.

## Interface
- `MAX_LEN`, 8: maximum payload bytes per frame (1..255).
- `BPS`, 9600: baud rate, passed to `uart_rx`.
- `CLK_FRE`, 50_000_000: input clock frequency in Hz, passed to `uart_rx`.
- `TIMEOUT_CLKS`, 30*(CLK_FRE/BPS): inter-byte idle limit in clocks (3 byte times).
- `sys_clk` in 1: system clock. One clock domain only.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `uart_rxd` in 1: UART RX line.
- `frame_data` out MAX_LEN*8: payload. First payload byte is in [7:0]. Bytes at index ≥ `frame_len` are 0.
- `frame_len` out 8: payload length of the last good frame.
- `frame_vld` out 1: 1-cycle pulse when a good frame is delivered.
- `frame_err` out 1: 1-cycle pulse when a frame is aborted.
- `err_code` out 2: cause of the last abort. 0 none, 1 bad length, 2 checksum, 3 timeout.

## Operation
- Frame format: `0x55`, `0xAA`, LEN, LEN payload bytes, CHK. CHK is the 8-bit sum, mod 256, of LEN and all payload bytes.
- The FSM advances only on the `uart_rx_done` pulse, using the data on `uart_rx_data`.
- FSM states and transitions:
  - IDLE: byte `0x55` → HDR1. Any other byte → stay in IDLE.
  - HDR1:
    - `0xAA` → LEN.
    - `0x55` → stay in HDR1.
    - Any other byte → IDLE, with no error.
  - LEN:
    - LEN = 0 or LEN > MAX_LEN → IDLE, with `frame_err` and `err_code`=1.
    - Otherwise: latch the length, set sum = LEN, clear the shadow buffer, set idx = 0, go to DATA.
  - DATA: write the byte to shadow[idx], add it to sum (8-bit wrap), increment idx. When idx = LEN-1 the next state is CHK.
  - CHK:
    - byte = sum → copy shadow to `frame_data` and LEN to `frame_len`, pulse `frame_vld`, go to IDLE.
    - Otherwise pulse `frame_err` with `err_code`=2 and go to IDLE.
- Timeout: the idle counter runs only in states other than IDLE and clears on every `uart_rx_done`. When it reaches TIMEOUT_CLKS-1 the block goes to IDLE and pulses `frame_err` with `err_code`=3.
- `frame_data` and `frame_len` change only on the `frame_vld` cycle. A partial or bad frame never corrupts them.
- `err_code` holds its last cause until the next error. It is not cleared by a good frame.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counters 0. Reset mid-frame discards the partial frame with no error pulse.
- Latency: `frame_vld` or `frame_err` is asserted in the cycle after the `uart_rx_done` that carries the deciding byte. For timeout, it is asserted in the cycle after the counter reaches its limit.
- `frame_vld` and `frame_err` are never high together. Each lasts exactly 1 cycle.
- If `uart_rx_done` and the timeout limit occur in the same cycle, the byte wins: it is processed and the counter clears.
- A byte arriving in the cycle the FSM returns to IDLE is evaluated under IDLE rules. A `0x55` CHK byte therefore does not start a new frame.
- The idx counter is 8 bits, and LEN is at most MAX_LEN, so idx cannot wrap.
- Back-to-back frames with no gap are supported.

## Structure
- Shared package `uart_frame_pkg` holds:
  - header constants `FRAME_H0=8'h55`, `FRAME_H1=8'hAA`
  - the FSM state encoding
  - error-code constants `ERR_NONE`, `ERR_LEN`, `ERR_CHK`, `ERR_TMO`
- One sub-module: the existing `uart_rx` (parameters `BPS`, `CLK_FRE`; ports `uart_rx_done`, `uart_rx_data`). It is instantiated unchanged.
- The timeout counter is sized `$clog2(TIMEOUT_CLKS)` and stays inline.

## Test plan
- Good frame. Stimulus: `55 AA 03 11 22 33 69`. Required: `frame_vld` pulse, `frame_len`=3, `frame_data`=`0x0000000000332211`, no `frame_err`.
- Bad checksum. Stimulus: `55 AA 03 11 22 33 68`. Required: `frame_err` with `err_code`=2. `frame_data` and `frame_len` keep their previous values.
- Bad length. Stimulus: `55 AA 00`, then `55 AA 09` with MAX_LEN=8. Required: two `frame_err` pulses, each with `err_code`=1.
- Resync. Stimulus: `12 55 55 AA 01 7F 80`. Required: `frame_vld`, `frame_len`=1, `frame_data`[7:0]=`0x7F`.
- Timeout. Stimulus: `55 AA 04 01 02`, then idle for more than TIMEOUT_CLKS. Required: `frame_err` with `err_code`=3 exactly TIMEOUT_CLKS cycles after the last `uart_rx_done`. A following good frame is then received correctly.
- Reset mid-frame. Stimulus: assert `sys_rst_n` low after `55 AA 02 AB`, then send `55 AA 01 05 06`. Required: all outputs 0 during reset, then one `frame_vld` with `frame_data`[7:0]=`0x05`.
